// File: rtl/bram_capture_ctrl.sv
// Trigger-armed sample capture into a BRAM write port with registered outputs.
// Optional feature macro: CAPTURE_DECIM_EN (store every (decim+1)-th valid sample).
module bram_capture_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [7:0]            decim,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [ADDR_WIDTH-1:0] bramaddr,
  output logic [DATA_WIDTH-1:0] bramval,
  output logic                  bramwe,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wcount
);

  localparam logic [ADDR_WIDTH:0]   CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [1:0]              r_rst_sync;
  logic                    w_rst_n;
  logic [ADDR_WIDTH:0]     r_len;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_bramaddr;
  logic [DATA_WIDTH-1:0]   r_bramval;
  logic                    r_bramwe;
  logic [ADDR_WIDTH:0]     r_wcount;
  logic [ADDR_WIDTH:0]     w_wcount_inc;
  logic                    r_trig_seen;
  logic                    w_accept_start;
  logic                    w_capture;
  logic                    w_enter_cap;
  logic                    w_last;
  logic                    w_dec_hit;

  // Assert asynchronously, release after two clocks so the first live cycle is IDLE.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_wcount_inc = (&r_wcount) ? r_wcount : r_wcount + CntOne;
  assign w_last       = (w_wcount_inc == r_len);

`ifdef CAPTURE_DECIM_EN
  logic [7:0] r_decim;
  logic [7:0] r_dec_cnt;

  assign w_dec_hit = (r_dec_cnt == r_decim);

  // Counts valid samples skipped since the last stored one.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_decim   <= 8'd0;
      r_dec_cnt <= 8'd0;
    end else begin
      if (w_accept_start) begin
        r_decim <= decim;
      end
      if (w_enter_cap) begin
        r_dec_cnt <= 8'd0;
      end else if ((r_state == StCapture) && din_valid && !abort) begin
        r_dec_cnt <= w_dec_hit ? 8'd0 : r_dec_cnt + 8'd1;
      end
    end
  end
`else
  logic w_unused_decim;

  assign w_dec_hit      = 1'b1;
  assign w_unused_decim = ^decim;
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept_start = 1'b0;
    w_capture      = 1'b0;
    w_enter_cap    = 1'b0;
    if (abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            w_accept_start = 1'b1;
            w_state_next   = (len == '0) ? StDone : StArmed;
          end
        end
        StArmed: begin
          if (din_valid && (trig || r_trig_seen)) begin
            w_capture    = 1'b1;
            w_enter_cap  = 1'b1;
            w_state_next = w_last ? StDone : StCapture;
          end
        end
        StCapture: begin
          if (din_valid && w_dec_hit) begin
            w_capture = 1'b1;
            if (w_last) begin
              w_state_next = StDone;
            end
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_len       <= '0;
      r_addr      <= '0;
      r_bramaddr  <= '0;
      r_bramval   <= '0;
      r_bramwe    <= 1'b0;
      r_wcount    <= '0;
      r_trig_seen <= 1'b0;
    end else begin
      r_bramwe <= w_capture;
      if (w_accept_start) begin
        r_len      <= len;
        r_addr     <= '0;
        r_bramaddr <= '0;
        r_wcount   <= '0;
      end
      if (w_capture) begin
        r_bramval  <= din;
        r_bramaddr <= r_addr;
        r_addr     <= r_addr + AddrOne;
        r_wcount   <= w_wcount_inc;
      end
      // A trigger seen without valid data is remembered until the first valid sample.
      if (abort || w_accept_start || w_enter_cap) begin
        r_trig_seen <= 1'b0;
      end else if ((r_state == StArmed) && trig) begin
        r_trig_seen <= 1'b1;
      end
    end
  end

  assign bramaddr = r_bramaddr;
  assign bramval  = r_bramval;
  assign bramwe   = r_bramwe;
  assign wcount   = r_wcount;
  assign busy     = (r_state == StArmed) || (r_state == StCapture);
  assign done     = (r_state == StDone);

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Directed vector bench for bram_capture_ctrl with a narrow address space (wrap coverage).
module tb_bram_capture_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          abort;
  logic          trig;
  logic [AW:0]   len;
  logic [7:0]    decim;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [AW-1:0] bramaddr;
  logic [DW-1:0] bramval;
  logic          bramwe;
  logic          busy;
  logic          done;
  logic [AW:0]   wcount;

  int n_checks = 0;
  int n_errors = 0;

  bram_capture_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) u_dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .start    (start),
    .abort    (abort),
    .trig     (trig),
    .len      (len),
    .decim    (decim),
    .din      (din),
    .din_valid(din_valid),
    .bramaddr (bramaddr),
    .bramval  (bramval),
    .bramwe   (bramwe),
    .busy     (busy),
    .done     (done),
    .wcount   (wcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic          ab;
    logic          tr;
    logic          dv;
    logic [AW:0]   len;
    logic [DW-1:0] din;
    int            we;
    int            addr;
    int            val;
    int            busy;
    int            done;
    int            wc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int st, input int ab, input int tr, input int dv,
                              input int l, input int d, input int we, input int a,
                              input int v, input int b, input int dn, input int wc);
    vec_t r;
    r.st   = 1'(st);
    r.ab   = 1'(ab);
    r.tr   = 1'(tr);
    r.dv   = 1'(dv);
    r.len  = 5'(l);
    r.din  = 16'(d);
    r.we   = we;
    r.addr = a;
    r.val  = v;
    r.busy = b;
    r.done = dn;
    r.wc   = wc;
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input int we, input int a, input int v,
                            input int b, input int dn, input int wc);
    check({nm, "_we"},   int'(bramwe),   we);
    check({nm, "_addr"}, int'(bramaddr), a);
    check({nm, "_val"},  int'(bramval),  v);
    check({nm, "_busy"}, int'(busy),     b);
    check({nm, "_done"}, int'(done),     dn);
    check({nm, "_wc"},   int'(wcount),   wc);
  endtask

  task automatic drive(input vec_t v);
    start     = v.st;
    abort     = v.ab;
    trig      = v.tr;
    din_valid = v.dv;
    len       = v.len;
    din       = v.din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    abort     = 1'b0;
    trig      = 1'b0;
    din_valid = 1'b0;
    len       = '0;
    decim     = 8'd0;
    din       = '0;
  endtask

  initial begin
    int            nw;
    logic [DW-1:0] wv [3];
    logic [AW-1:0] wa [3];
    int            exp_v [3];

    aresetn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    aresetn = 1'b1;
    repeat (3) step();
    check_outs("post_reset", 0, 0, 0, 0, 0, 0);

    // len=4 continuous
    vecs.push_back(mk(1, 0, 0, 0, 4, 0,     0, 0, 'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h10,  1, 0, 'h10, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h11,  1, 1, 'h11, 1, 0, 2));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h12,  1, 2, 'h12, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h13,  1, 3, 'h13, 0, 1, 4));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h14,  0, 3, 'h13, 0, 1, 4));
    // len=0 from DONE
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0, 'h13, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h15,  0, 0, 'h13, 0, 1, 0));
    // len=3, trigger without valid, then toggling valid, start ignored mid-capture
    vecs.push_back(mk(1, 0, 0, 0, 3, 0,     0, 0, 'h13, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 'h1f,  0, 0, 'h13, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h20,  1, 0, 'h20, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 'h21,  0, 0, 'h20, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h22,  1, 1, 'h22, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 'h23,  0, 1, 'h22, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h24,  1, 2, 'h24, 0, 1, 3));
    // abort beats start; len=8 aborted after 3 writes; restart at address 0
    vecs.push_back(mk(1, 1, 0, 0, 8, 0,     0, 2, 'h24, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 8, 0,     0, 0, 'h24, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h30,  1, 0, 'h30, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h31,  1, 1, 'h31, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h32,  1, 2, 'h32, 1, 0, 3));
    vecs.push_back(mk(0, 1, 1, 1, 0, 'h33,  0, 2, 'h32, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h34,  0, 2, 'h32, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 2, 0,     0, 0, 'h32, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h40,  1, 0, 'h40, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h41,  1, 1, 'h41, 0, 1, 2));
    // abort in ARMED wins over trigger with valid data
    vecs.push_back(mk(1, 0, 0, 0, 2, 0,     0, 0, 'h41, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 'h50,  0, 0, 'h41, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].val,
                 vecs[i].busy, vecs[i].done, vecs[i].wc);
    end
    idle_inputs();

    // len=20 on a 16-word space: addresses wrap 0..15,0..3
    start = 1'b1;
    len   = 5'd20;
    step();
    start = 1'b0;
    check("wrap_armed", int'(busy), 1);
    for (int i = 0; i < 20; i++) begin
      trig      = 1'b1;
      din_valid = 1'b1;
      din       = 16'(32'h100 + i);
      step();
      check_outs($sformatf("wrap%0d", i), 1, i % 16, 'h100 + i,
                 (i == 19) ? 0 : 1, (i == 19) ? 1 : 0, i + 1);
    end
    din = 16'h1ff;
    step();
    check_outs("wrap_hold", 0, 3, 'h113, 0, 1, 20);
    idle_inputs();

    // decim=2, len=3, continuous valid din=0..11
    start = 1'b1;
    len   = 5'd3;
    decim = 8'd2;
    step();
    start = 1'b0;
    decim = 8'd0;
    nw    = 0;
    for (int i = 0; i < 12; i++) begin
      trig      = 1'b1;
      din_valid = 1'b1;
      din       = 16'(i);
      step();
      if (bramwe) begin
        if (nw < 3) begin
          wv[nw] = bramval;
          wa[nw] = bramaddr;
        end
        nw++;
      end
    end
`ifdef CAPTURE_DECIM_EN
    exp_v = '{0, 3, 6};
`else
    exp_v = '{0, 1, 2};
`endif
    check("dec_nwrites", nw, 3);
    for (int k = 0; k < 3; k++) begin
      if (k < nw) begin
        check($sformatf("dec_val%0d", k), int'(wv[k]), exp_v[k]);
        check($sformatf("dec_addr%0d", k), int'(wa[k]), k);
      end
    end
    check("dec_done", int'(done), 1);
    check("dec_wc", int'(wcount), 3);
    idle_inputs();

    // asynchronous reset in the middle of a capture
    start = 1'b1;
    len   = 5'd10;
    step();
    start     = 1'b0;
    trig      = 1'b1;
    din_valid = 1'b1;
    din       = 16'h60;
    step();
    din = 16'h61;
    step();
    check_outs("pre_rst", 1, 1, 'h61, 1, 0, 2);
    din = 16'h62;
    #2;
    aresetn = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 16'(32'h70 + i);
      step();
      check_outs($sformatf("rst_rel%0d", i), 0, 0, 0, 0, 0, 0);
    end
    trig      = 1'b0;
    din_valid = 1'b0;
    start     = 1'b1;
    len       = 5'd1;
    step();
    start = 1'b0;
    check_outs("rst_restart", 0, 0, 0, 1, 0, 0);
    trig      = 1'b1;
    din_valid = 1'b1;
    din       = 16'h77;
    step();
    check_outs("rst_len1", 1, 0, 'h77, 0, 1, 1);
    idle_inputs();
    step();
    check_outs("rst_len1_hold", 0, 0, 'h77, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_capture_ctrl.md
BRAM_CAPTURE_CTRL -- requirements
Module: bram_capture_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, BRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 64, sample/BRAM data width.
REQ-003 Port clk, input, 1, single clock (dspclk domain); all logic on posedge.
REQ-004 Port aresetn, input, 1; reset is asynchronous and active-low.
REQ-005 Port start, input, 1, single-cycle arm request.
REQ-006 Port abort, input, 1, single-cycle cancel request.
REQ-007 Port trig, input, 1, capture trigger, sampled each cycle.
REQ-008 Port len, input, ADDR_WIDTH+1, number of samples to capture; latched on accepted start.
REQ-009 Port decim, input, 8, decimation factor minus one; used only with CAPTURE_DECIM_EN.
REQ-010 Port din, input, DATA_WIDTH, ADC sample.
REQ-011 Port din_valid, input, 1, din qualifier.
REQ-012 Port bramaddr, output, ADDR_WIDTH, BRAM word address.
REQ-013 Port bramval, output, DATA_WIDTH, BRAM write data.
REQ-014 Port bramwe, output, 1, BRAM write enable.
REQ-015 Port busy, output, 1, high in ARMED or CAPTURE.
REQ-016 Port done, output, 1, high in DONE.
REQ-017 Port wcount, output, ADDR_WIDTH+1, samples written in current/last capture.

Function
REQ-018 FSM states IDLE, ARMED, CAPTURE, DONE; reset state IDLE.
REQ-019 IDLE or DONE + start: latch len, clear wcount and address to 0, go ARMED next cycle; if latched len=0 go DONE instead, no writes.
REQ-020 start in ARMED or CAPTURE: ignored.
REQ-021 abort in any state: IDLE next cycle, bramwe low that cycle; abort wins over simultaneous start/trig.
REQ-022 ARMED + trig + din_valid: that din is first sample; state CAPTURE.
REQ-023 ARMED + trig without din_valid: trigger latched; first valid sample afterwards is first sample.
REQ-024 Every captured sample produces bramwe=1 exactly one cycle later with bramval=din and bramaddr=current address (registered outputs, latency 1).
REQ-025 Address increments by 1 after each write, wraps at 2^ADDR_WIDTH-1 to 0; len > 2^ADDR_WIDTH overwrites from 0.
REQ-026 wcount increments with each bramwe; saturates at all-ones.
REQ-027 After the write making wcount equal latched len, state DONE the same cycle bramwe is asserted; no further writes.
REQ-028 din_valid low in CAPTURE: no write, no address change.
REQ-029 DONE held until start or abort; wcount and bramaddr hold last values.
REQ-030 trig ignored outside ARMED.

Reset
REQ-031 aresetn low: state IDLE, bramaddr=0, bramval=0, bramwe=0, busy=0, done=0, wcount=0, decimation counter=0, latched len=0, asynchronously.
REQ-032 Reset mid-capture aborts without further writes; release synchronized internally (two-flop deassert) so first post-reset cycle is IDLE.

Configuration
REQ-033 Macro CAPTURE_DECIM_EN defined: capture only every (decim+1)-th valid sample, counter cleared on entering CAPTURE, first valid sample after trigger always captured; decim latched on accepted start.
REQ-034 Macro CAPTURE_DECIM_EN undefined: every valid sample in CAPTURE captured; decim port present but ignored, no counter logic.

Verification
REQ-035 len=4, start, trig with din_valid continuous, din=0x10..0x13 -> bramwe 4 cycles, addr 0..3, data 0x10..0x13, done=1, wcount=4.
REQ-036 len=0, start -> done=1 next cycle, bramwe never asserted, wcount=0.
REQ-037 len=3, din_valid toggling 1,0,1,0,1 after trig -> writes only on valid cycles, addresses 0,1,2, done after third write.
REQ-038 len=8, abort after 3 writes -> IDLE, wcount=3, no further bramwe; new start restarts at addr 0.
REQ-039 ADDR_WIDTH=4, len=20 -> addresses 0..15,0..3, wcount=20, done=1.
REQ-040 CAPTURE_DECIM_EN, decim=2, len=3, continuous valid din=0..8 -> writes 0,3,6 at addr 0,1,2.
